// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction memory loader: FSM state encoding
// and default geometry / fill constants.
package instr_mem_loader_pkg;

    localparam int DEF_ISIZE  = 16;
    localparam int DEF_ADDR_W = 8;
    localparam logic [DEF_ISIZE-1:0] DEF_FILL_WORD = '0;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_LOAD  = 2'd2
    } state_e;

endpackage

// File: rtl/instr_mem_loader_if.sv
// Read port, load stream and status signals of the instruction memory loader.
// The master side drives requests and load words; the slave side is the loader.
interface instr_mem_loader_if
    import instr_mem_loader_pkg::*;
#(
    parameter int ISIZE  = DEF_ISIZE,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [ISIZE-1:0]  rd_data;
    logic              rd_valid;
    logic              ld_start;
    logic              ld_valid;
    logic [ISIZE-1:0]  ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic              busy;
    logic [ADDR_W:0]   ld_count;
    logic              ld_ovf;

    modport master (
        output rd_en, rd_addr, ld_start, ld_valid, ld_data, ld_last,
        input  rd_data, rd_valid, ld_ready, busy, ld_count, ld_ovf
    );

    modport slave (
        input  rd_en, rd_addr, ld_start, ld_valid, ld_data, ld_last,
        output rd_data, rd_valid, ld_ready, busy, ld_count, ld_ovf
    );
endinterface

// File: rtl/instr_mem_loader_imem_array.sv
// Instruction storage: one synchronous write port and one registered read
// port. The read register resets to RST_WORD; the array itself is not reset.
module imem_array #(
    parameter int               ISIZE    = 16,
    parameter int               ADDR_W   = 8,
    parameter logic [ISIZE-1:0] RST_WORD = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [ISIZE-1:0]  wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [ISIZE-1:0]  rd_data_o
);
    logic [ISIZE-1:0] mem_q [2**ADDR_W];
    logic [ISIZE-1:0] rd_data_q;

    // Write port.
    // NOTE: the storage array gets no reset so it maps onto RAM macros; any
    // required initial contents come from the loader's CLEAR sweep instead.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read port; holds its value when no read is requested.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data_q <= RST_WORD;
        end else if (re_i) begin
            rd_data_q <= mem_q[raddr_i];
        end
    end

    assign rd_data_o = rd_data_q;
endmodule

// File: rtl/instr_mem_loader.sv
// Instruction memory loader: fills memory from a valid/ready word stream and
// serves single-cycle-latency reads while idle.
// Build option: define IMEM_CLEAR_EN to sweep FILL_WORD through the whole
// array after reset (CLEAR state); otherwise reset lands directly in IDLE.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int               ISIZE     = DEF_ISIZE,
    parameter int               ADDR_W    = DEF_ADDR_W,
    parameter logic [ISIZE-1:0] FILL_WORD = ISIZE'(DEF_FILL_WORD)
) (
    input  logic clk,
    input  logic rst,
    instr_mem_loader_if.slave bus
);
`ifdef IMEM_CLEAR_EN
    localparam state_e RESET_STATE = ST_CLEAR;
`else
    localparam state_e RESET_STATE = ST_IDLE;
`endif
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   ld_count_q, ld_count_d;
    logic              ld_ovf_q, ld_ovf_d;
    logic              rd_valid_q;
    logic              we;
    logic              array_we;
    logic [ISIZE-1:0]  wdata;
    logic              rd_fire;

    // Reads are only served while no clear or load owns the array.
    assign rd_fire = bus.rd_en && (state_q == ST_IDLE);

    // State, pointer and load status registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= RESET_STATE;
            wr_ptr_q   <= '0;
            ld_count_q <= '0;
            ld_ovf_q   <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            ld_count_q <= ld_count_d;
            ld_ovf_q   <= ld_ovf_d;
            rd_valid_q <= rd_fire;
        end
    end

    // Next-state logic and write-port control.
    // NOTE: every signal gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        ld_count_d = ld_count_q;
        ld_ovf_d   = ld_ovf_q;
        we         = 1'b0;
        wdata      = FILL_WORD;
        case (state_q)
`ifdef IMEM_CLEAR_EN
            ST_CLEAR: begin
                we = 1'b1;
                if (wr_ptr_q == LAST_ADDR) begin
                    state_d  = ST_IDLE;
                    wr_ptr_d = '0;
                end else begin
                    wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                end
            end
`endif
            ST_IDLE: begin
                if (bus.ld_start) begin
                    state_d    = ST_LOAD;
                    wr_ptr_d   = '0;
                    ld_count_d = '0;
                    ld_ovf_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (bus.ld_valid) begin
                    we         = 1'b1;
                    wdata      = bus.ld_data;
                    ld_count_d = ld_count_q + (ADDR_W+1)'(1);
                    if (bus.ld_last) begin
                        state_d = ST_IDLE;
                    end else if (wr_ptr_q == LAST_ADDR) begin
                        // Array full without an end marker: stop, never wrap.
                        ld_ovf_d = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A reset cycle must not disturb memory on behalf of an aborted operation.
    assign array_we = we && rst;

    imem_array #(
        .ISIZE   (ISIZE),
        .ADDR_W  (ADDR_W),
        .RST_WORD(FILL_WORD)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .we_i     (array_we),
        .waddr_i  (wr_ptr_q),
        .wdata_i  (wdata),
        .re_i     (rd_fire),
        .raddr_i  (bus.rd_addr),
        .rd_data_o(bus.rd_data)
    );

    assign bus.rd_valid = rd_valid_q;
    assign bus.ld_ready = (state_q == ST_LOAD);
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.ld_count = ld_count_q;
    assign bus.ld_ovf   = ld_ovf_q;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader (ISIZE=16, ADDR_W=4). Works with
// and without IMEM_CLEAR_EN; without it, memory is first filled with zeros.
module tb_instr_mem_loader;
    localparam int ISIZE  = 16;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 2**ADDR_W;

    logic clk = 1'b0;
    logic rst = 1'b0;

    instr_mem_loader_if #(.ISIZE(ISIZE), .ADDR_W(ADDR_W)) bus ();

    instr_mem_loader #(
        .ISIZE    (ISIZE),
        .ADDR_W   (ADDR_W),
        .FILL_WORD(16'h0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              rd_en;
        logic [ADDR_W-1:0] addr;
        logic              exp_valid;
        logic [ISIZE-1:0]  exp_data;
    } vec_t;

    int n_checks = 0;
    int n_err    = 0;
    logic [ISIZE-1:0] mdl [DEPTH];
    logic [ISIZE-1:0] exp_q [$];
    logic [ISIZE-1:0] exp_hold;
`ifdef IMEM_CLEAR_EN
    localparam logic EXP_BUSY_RST = 1'b1;
`else
    localparam logic EXP_BUSY_RST = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single read through the scoreboard: expectation pushed at request time.
    task automatic rd_chk(input int addr);
        bus.rd_en   = 1'b1;
        bus.rd_addr = ADDR_W'(addr);
        exp_q.push_back(mdl[addr]);
        step();
        bus.rd_en = 1'b0;
        check($sformatf("rd_valid[%0d]", addr), bus.rd_valid, 1'b1);
        if (exp_q.size() > 0) begin
            exp_hold = exp_q.pop_front();
            check($sformatf("rd_data[%0d]", addr), bus.rd_data, exp_hold);
        end
    endtask

    // Streams n words (base + stride*i) into a fresh load and updates the model.
    task automatic do_load(input int n, input logic [ISIZE-1:0] base, input logic [ISIZE-1:0] stride,
                           input bit use_last, input bit rand_valid, input bit rd_too);
        int idx = 0;
        int cyc = 0;
        int mptr = 0;
        logic [ISIZE-1:0] d;
        bus.ld_start = 1'b1;
        if (rd_too) begin
            bus.rd_en   = 1'b1;
            bus.rd_addr = '0;
            exp_q.push_back(mdl[0]);
        end
        step();
        bus.ld_start = 1'b0;
        if (rd_too) begin
            check("rd_with_start_valid", bus.rd_valid, 1'b1);
            if (exp_q.size() > 0) begin
                exp_hold = exp_q.pop_front();
                check("rd_with_start_data", bus.rd_data, exp_hold);
            end
        end
        check("ld_ready_in_load", bus.ld_ready, 1'b1);
        check("busy_in_load", bus.busy, 1'b1);
        while (idx < n && bus.ld_ready && cyc < 500) begin
            bus.ld_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            d = base + stride * ISIZE'(idx);
            bus.ld_data  = d;
            bus.ld_last  = use_last && (idx == n - 1);
            bus.ld_start = rand_valid && (idx == 2);
            if (bus.ld_valid) begin
                mdl[mptr] = d;
                mptr++;
                idx++;
            end
            step();
            if (rd_too) begin
                check("rd_valid_busy", bus.rd_valid, 1'b0);
                check("rd_data_busy_hold", bus.rd_data, exp_hold);
            end
            cyc++;
        end
        if (cyc >= 500) begin
            n_checks++;
            n_err++;
            $display("FAIL load_timeout: got %0d words, expected %0d", idx, n);
        end
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        bus.ld_start = 1'b0;
        bus.rd_en    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs [6];
        int n;

        vecs[0] = '{1'b1, 4'd0, 1'b1, 16'h1111};
        vecs[1] = '{1'b1, 4'd1, 1'b1, 16'h2222};
        vecs[2] = '{1'b0, 4'd0, 1'b0, 16'h2222};
        vecs[3] = '{1'b1, 4'd2, 1'b1, 16'h3333};
        vecs[4] = '{1'b1, 4'd3, 1'b1, 16'h0000};
        vecs[5] = '{1'b0, 4'd3, 1'b0, 16'h0000};

        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        bus.rd_en = 1'b0; bus.rd_addr = '0; bus.ld_start = 1'b0;
        bus.ld_valid = 1'b0; bus.ld_data = '0; bus.ld_last = 1'b0;
        exp_hold = '0;

        // Reset state.
        step();
        step();
        check("rst_rd_data", bus.rd_data, 16'h0000);
        check("rst_rd_valid", bus.rd_valid, 1'b0);
        check("rst_ld_count", bus.ld_count, 0);
        check("rst_ld_ovf", bus.ld_ovf, 1'b0);
        check("rst_ld_ready", bus.ld_ready, 1'b0);
        check("rst_busy", bus.busy, EXP_BUSY_RST);
        rst = 1'b1;

`ifdef IMEM_CLEAR_EN
        // Clear sweep: busy for exactly DEPTH cycles.
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            step();
        end
        check("clear_busy_cycles", n, DEPTH);
`else
        // No clear: give the array known contents with an all-zero load.
        n = 0;
        do_load(DEPTH, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
        check("init_ld_count", bus.ld_count, DEPTH);
`endif
        check("idle_ld_ready", bus.ld_ready, 1'b0);
        for (int a = 0; a < DEPTH; a++) rd_chk(a);

        // Load three words, first cycle shared with a read of pre-load data.
        do_load(3, 16'h1111, 16'h1111, 1'b1, 1'b0, 1'b1);
        check("load_ld_count", bus.ld_count, 3);
        check("load_ld_ovf", bus.ld_ovf, 1'b0);
        check("load_busy_done", bus.busy, 1'b0);
        for (int i = 0; i < 6; i++) begin
            bus.rd_en   = vecs[i].rd_en;
            bus.rd_addr = vecs[i].addr;
            if (vecs[i].rd_en) exp_q.push_back(vecs[i].exp_data);
            step();
            check($sformatf("tbl_valid[%0d]", i), bus.rd_valid, vecs[i].exp_valid);
            if (bus.rd_valid && exp_q.size() > 0) begin
                exp_hold = exp_q.pop_front();
                check($sformatf("tbl_data[%0d]", i), bus.rd_data, exp_hold);
            end else begin
                check($sformatf("tbl_hold[%0d]", i), bus.rd_data, vecs[i].exp_data);
            end
        end
        bus.rd_en = 1'b0;

        // Backpressure: random ld_valid, stray ld_start mid-load.
        do_load(5, 16'hA000, 16'h0001, 1'b1, 1'b1, 1'b0);
        check("bp_ld_count", bus.ld_count, 5);
        check("bp_ld_ovf", bus.ld_ovf, 1'b0);
        for (int a = 5; a >= 0; a--) rd_chk(a);

        // Overflow: 17 words without last; reads attempted during the load.
        do_load(17, 16'hB000, 16'h0001, 1'b0, 1'b0, 1'b1);
        check("ovf_ld_count", bus.ld_count, DEPTH);
        check("ovf_flag", bus.ld_ovf, 1'b1);
        check("ovf_busy", bus.busy, 1'b0);
        check("ovf_ld_ready", bus.ld_ready, 1'b0);
        bus.ld_valid = 1'b1;
        bus.ld_data  = 16'hB010;
        step();
        bus.ld_valid = 1'b0;
        check("ovf_17th_ignored", bus.ld_count, DEPTH);
        rd_chk(0);
        rd_chk(DEPTH - 1);

        // Abort: reset after 2 of 4 words.
        bus.ld_start = 1'b1;
        step();
        bus.ld_start = 1'b0;
        bus.ld_valid = 1'b1;
        bus.ld_data  = 16'hC000;
        step();
        bus.ld_data  = 16'hC001;
        step();
        check("abort_pre_count", bus.ld_count, 2);
        bus.ld_data = 16'hC002;
        rst = 1'b0;
        step();
        check("abort_ld_count", bus.ld_count, 0);
        check("abort_ld_ovf", bus.ld_ovf, 1'b0);
        check("abort_rd_valid", bus.rd_valid, 1'b0);
        check("abort_ld_ready", bus.ld_ready, 1'b0);
        check("abort_busy", bus.busy, EXP_BUSY_RST);
        rst = 1'b1;
        bus.ld_valid = 1'b0;
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            step();
        end
        check("abort_settles_idle", bus.busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 SHALL have parameter ISIZE, default 16, meaning instruction word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 8, meaning address width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter FILL_WORD, default all-zero ISIZE bits, meaning the value written by clear and returned when no word was loaded.
REQ-004 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-006 SHALL have ports rd_en  in  1 (read request) and rd_addr  in  ADDR_W (read address).
REQ-007 SHALL have ports rd_data  out  ISIZE (registered read word) and rd_valid  out  1 (rd_data valid this cycle).
REQ-008 SHALL have ports ld_start  in  1 (begin load), ld_valid  in  1, ld_data  in  ISIZE and ld_last  in  1 (final word marker).
REQ-009 SHALL have port ld_ready  out  1, meaning a word is accepted on the cycle where ld_valid and ld_ready are both 1.
REQ-010 SHALL have ports busy  out  1 (clear or load in progress), ld_count  out  ADDR_W+1 (words accepted in the last load) and ld_ovf  out  1 (sticky overflow).

Function
REQ-011 SHALL implement FSM states CLEAR, IDLE and LOAD.
REQ-012 CLEAR SHALL write FILL_WORD to one address per cycle, ascending from 0; after address 2**ADDR_W-1 it SHALL go to IDLE.
REQ-013 IDLE with ld_start=1 SHALL go to LOAD next cycle, with write pointer=0, ld_count=0 and ld_ovf=0.
REQ-014 LOAD SHALL assert ld_ready=1; each accepted word SHALL be written at the pointer, and the pointer and ld_count SHALL increment.
REQ-015 Accepting a word with ld_last=1 SHALL return the FSM to IDLE next cycle; un-loaded addresses keep their previous contents.
REQ-016 Accepting a word at address 2**ADDR_W-1 with ld_last=0 SHALL write it, set ld_ovf=1 and return to IDLE; the pointer SHALL NOT wrap.
REQ-017 ld_ready SHALL be 0 in CLEAR and IDLE; ld_valid outside LOAD SHALL be ignored.
REQ-018 busy SHALL be 1 exactly while the state is CLEAR or LOAD.
REQ-019 In IDLE, rd_en=1 SHALL give rd_data=mem[rd_addr] and rd_valid=1 on the next cycle (latency 1).
REQ-020 When rd_en=0, or the FSM is busy, the next cycle SHALL have rd_valid=0 and rd_data held at its previous value.
REQ-021 ld_start and rd_en in the same IDLE cycle: the read SHALL complete with pre-load data, and the FSM SHALL enter LOAD.
REQ-022 ld_start while busy SHALL be ignored.

Reset
REQ-023 rst=0 at a clock edge SHALL give rd_data=FILL_WORD, rd_valid=0, ld_count=0, ld_ovf=0 and ld_ready=0.
REQ-024 The state after reset SHALL be CLEAR (busy=1) with IMEM_CLEAR_EN defined, else IDLE (busy=0).
REQ-025 Reset mid-LOAD or mid-CLEAR SHALL abort the operation; partially written words SHALL NOT be relied upon.

Configuration
REQ-026 Macro IMEM_CLEAR_EN defined: the CLEAR state and its 2**ADDR_W-cycle sweep SHALL be compiled in.
REQ-027 IMEM_CLEAR_EN undefined: CLEAR SHALL be absent, and memory contents after reset SHALL be undefined until loaded.

Structure
REQ-028 The shared define package SHALL hold the FSM state encoding and default ISIZE/ADDR_W/FILL_WORD constants.
REQ-029 Storage SHALL be a sub-module imem_array: one write port and one registered read port, parametrised by ISIZE and ADDR_W.

Verification
REQ-030 Clear scenario (IMEM_CLEAR_EN, ADDR_W=4): release reset -> busy=1 for 16 cycles then 0; read every address -> 0x0000, rd_valid=1 one cycle after rd_en.
REQ-031 Load scenario: load 0x1111, 0x2222, 0x3333 (last on third) -> ld_count=3, ld_ovf=0; addresses 0..2 read 0x1111/0x2222/0x3333, address 3 reads 0x0000.
REQ-032 Backpressure scenario: toggle ld_valid randomly during a 5-word load -> exactly 5 writes, ld_count=5, no duplicated or lost word.
REQ-033 Overflow scenario (ADDR_W=4): send 17 words, none with last -> 16 accepted, ld_ovf=1, FSM in IDLE, ld_ready=0, address 0 holds word 0.
REQ-034 Abort scenario: assert rst=0 after 2 of 4 load words -> next cycle ld_count=0, ld_ovf=0, rd_valid=0; busy per REQ-024.
REQ-035 Read-during-busy scenario: rd_en=1 during LOAD -> rd_valid=0 and rd_data unchanged.
